rx_sweep_ctrl: RTL

RX_SWEEP_CTRL -- requirements
Module: rx_sweep_ctrl

---
 rtl/rx_sweep_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_sweep_ctrl.sv
// Purpose: frequency-sweep sequencer; retunes the RX downconverter, settles, averages magnitude per point.
// Latency: result valid 1 cycle after the 2^k-th averaged sample; phase_inc valid 1 cycle after start.
// Backpressure: res_valid/res_ready; while stalled, ce_down samples are dropped and nothing advances.
// Optional build macro RX_SWEEP_PHASE_CAPTURE_EN: when defined, res_phase carries the last sample's phase.
module rx_sweep_ctrl #(
    parameter int PW  = 19,
    parameter int MW  = 16,
    parameter int PHW = 25
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PW-1:0]         cfg_f_start,
    input  logic [PW-1:0]         cfg_f_step,
    input  logic [15:0]           cfg_n_points,
    input  logic [15:0]           cfg_settle,
    input  logic [2:0]            cfg_avg_log2,
    output logic [PW-1:0]         phase_inc,
    input  logic                  ce_down,
    input  logic signed [MW-1:0]  rx_magnitude,
    input  logic signed [PHW-1:0] rx_phase,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_index,
    output logic signed [MW-1:0]  res_mag,
    output logic signed [PHW-1:0] res_phase,
    output logic                  busy,
    output logic                  done
);

    // Accumulator is 8 bits wider than a sample so 128 full-scale samples cannot overflow.
    localparam int AW = MW + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_OUTPUT,
        S_FINISH
    } state_t;

    // Sweep configuration captured at the accepted start (f_start goes straight into phase_inc).
    typedef struct packed {
        logic [PW-1:0] f_step;
        logic [15:0]   n_points;
        logic [15:0]   settle;
        logic [2:0]    avg_log2;
    } cfg_t;

    state_t               state;
    state_t               state_nxt;
    cfg_t                 cfg_q;
    logic [15:0]          settle_cnt;
    logic [7:0]           samp_cnt;
    logic [7:0]           avg_last;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] shifted;
    logic                 unused_hi;

    logic accept;
    logic take;
    logic last_take;
    logic handshake;
    logic last_point;

    assign avg_last  = (8'd1 << cfg_q.avg_log2) - 8'd1;
    assign acc_sum   = acc + {{8{rx_magnitude[MW-1]}}, rx_magnitude};
    assign shifted   = acc_sum >>> cfg_q.avg_log2;
    assign unused_hi = ^shifted[AW-1:MW];

    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_OUTPUT);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes; abort overrides everything.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        take       = 1'b0;
        last_take  = 1'b0;
        handshake  = 1'b0;
        last_point = 1'b0;
        case (state)
            S_IDLE: begin
                // The done cycle is itself IDLE; a start landing on it is dropped.
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = (cfg_n_points == 16'd0) ? S_FINISH : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cfg_q.settle == 16'd0) begin
                    state_nxt = S_ACCUM;
                end else if (ce_down &&
                             ({1'b0, settle_cnt} + 17'd1 == {1'b0, cfg_q.settle})) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (ce_down) begin
                    take = 1'b1;
                    if (samp_cnt == avg_last) begin
                        last_take = 1'b1;
                        state_nxt = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    handshake  = 1'b1;
                    last_point = (res_index == cfg_q.n_points - 16'd1);
                    state_nxt  = last_point ? S_FINISH : S_SETTLE;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
            take      = 1'b0;
            last_take = 1'b0;
            handshake = 1'b0;
        end
    end

    // Settle counter runs only while staying in SETTLE, so each retune starts from zero.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE && state_nxt == S_SETTLE) begin
            if (ce_down) begin
                settle_cnt <= settle_cnt + 16'd1;
            end
        end else begin
            settle_cnt <= '0;
        end
    end

    // Config capture, tuning word, point index, accumulator and result magnitude.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            phase_inc <= '0;
            res_index <= '0;
            res_mag   <= '0;
            acc       <= '0;
            samp_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_FINISH) && !abort;
            if (accept) begin
                cfg_q.f_step   <= cfg_f_step;
                cfg_q.n_points <= cfg_n_points;
                cfg_q.settle   <= cfg_settle;
                cfg_q.avg_log2 <= cfg_avg_log2;
                phase_inc      <= cfg_f_start;
                res_index      <= '0;
                acc            <= '0;
                samp_cnt       <= '0;
            end
            if (take) begin
                acc      <= acc_sum;
                samp_cnt <= samp_cnt + 8'd1;
            end
            if (last_take) begin
                res_mag  <= shifted[MW-1:0];
                samp_cnt <= '0;
            end
            if (handshake && !last_point) begin
                phase_inc <= phase_inc + cfg_q.f_step;
                res_index <= res_index + 16'd1;
                acc       <= '0;
            end
            if (abort) begin
                acc      <= '0;
                samp_cnt <= '0;
            end
        end
    end

`ifdef RX_SWEEP_PHASE_CAPTURE_EN
    // Phase of the final averaged sample of each point.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            res_phase <= '0;
        end else if (last_take) begin
            res_phase <= rx_phase;
        end
    end
`else
    logic unused_phase;
    assign unused_phase = ^rx_phase;
    assign res_phase    = '0;
`endif

endmodule
